// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, mcause codes,
// FSM state encoding and the store-lane replication helper.
package lsu_pkg;

   localparam int unsigned F3W = 3;

   // funct3 access encodings
   localparam logic [F3W-1:0] F3Byte  = 3'd0;
   localparam logic [F3W-1:0] F3Half  = 3'd1;
   localparam logic [F3W-1:0] F3Word  = 3'd2;
   localparam logic [F3W-1:0] F3ByteU = 3'd4;
   localparam logic [F3W-1:0] F3HalfU = 3'd5;

   // mcause codes reported to the trap logic
   localparam logic [3:0] CauseIllegal    = 4'd2;
   localparam logic [3:0] CauseLdMisalign = 4'd4;
   localparam logic [3:0] CauseLdFault    = 4'd5;
   localparam logic [3:0] CauseStMisalign = 4'd6;
   localparam logic [3:0] CauseStFault    = 4'd7;

   // FSM state encoding
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   // Replicate the stored byte/half across all lanes so the byte enables alone
   // pick the destination lane.
   function automatic logic [31:0] store_lanes(input logic [F3W-1:0] f3, input logic [31:0] data);
      logic [31:0] lanes;
      case (f3[1:0])
         2'b00:   lanes = {4{data[7:0]}};
         2'b01:   lanes = {2{data[15:0]}};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding req/ack data bus between the LSU (master) and memory (slave).
interface load_store_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      be;
   logic            ack;
   logic [XLEN-1:0] rdata;
   logic            err;

   modport master (
      output req, we, addr, wdata, be,
      input  ack, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ack, rdata, err
   );
endinterface

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the addressed lane of a bus word
// and sign- or zero-extends it according to funct3.
module load_formatter
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [F3W-1:0]  f3_i,
   output logic [XLEN-1:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select by the low address bits
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Width and extension by funct3
   always_comb begin
      case (f3_i)
         F3Byte:  result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3Half:  result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3ByteU: result_o = {{(XLEN-8){1'b0}}, byte_sel};
         F3HalfU: result_o = {{(XLEN-16){1'b0}}, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: validates the decoder's request, runs one bus
// transfer at a time, stalls the pipeline while busy and reports exceptions.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned XLEN    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_MemRead,
   input  logic            i_MemWrite,
   input  logic [F3W-1:0]  i_f3,
   input  logic [XLEN-1:0] i_Addr,
   input  logic [XLEN-1:0] i_WrData,
   output logic [XLEN-1:0] o_RdData,
   output logic            o_Stall,
   output logic            o_Ex,
   output logic [3:0]      o_ExCause,
   output logic [XLEN-1:0] o_ExAddr,
   load_store_unit_if.master dbus
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q;
   logic            we_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;
   logic [F3W-1:0]  f3_q;
   logic            fault_q;
   logic [XLEN-1:0] rdata_q;

   logic            req_valid;
   logic            is_store;
   logic            width_ok;
   logic            misalign;
   logic            chk_fail;
   logic [3:0]      chk_cause;
   logic [3:0]      be_new;
   logic            accept;
   logic            timeout_hit;
   logic            idle_fault;
   logic            done_fault;
   logic [XLEN-1:0] fmt_data;

   // Request decode: width legality, alignment and byte enables
   always_comb begin
      req_valid = i_MemRead | i_MemWrite;
      is_store  = i_MemWrite;
      if (is_store) begin
         width_ok = (i_f3 == F3Byte) || (i_f3 == F3Half) || (i_f3 == F3Word);
      end else begin
         width_ok = (i_f3 == F3Byte) || (i_f3 == F3Half) || (i_f3 == F3Word) ||
                    (i_f3 == F3ByteU) || (i_f3 == F3HalfU);
      end
      case (i_f3[1:0])
         2'b01:   misalign = i_Addr[0];
         2'b10:   misalign = |i_Addr[1:0];
         default: misalign = 1'b0;
      endcase
      chk_fail = !width_ok || misalign;
      if (!width_ok) begin
         chk_cause = CauseIllegal;
      end else begin
         chk_cause = is_store ? CauseStMisalign : CauseLdMisalign;
      end
      case (i_f3[1:0])
         2'b00:   be_new = 4'b0001 << i_Addr[1:0];
         2'b01:   be_new = 4'b0011 << i_Addr[1:0];
         default: be_new = 4'b1111;
      endcase
   end

   assign accept      = (state_q == StIdle) && req_valid && !chk_fail;
   // Compare against TIMEOUT-1 so req is held for exactly TIMEOUT cycles
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

   // Next-state and wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (accept) state_d = StBusy;
         end
         StBusy: begin
            cnt_d = cnt_q + 1'b1;
            if (dbus.ack || timeout_hit) state_d = StDone;
         end
         StDone: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Transfer latch on accept; fault flag and load result on completion
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= i_Addr;
            we_q    <= is_store;
            be_q    <= be_new;
            wdata_q <= XLEN'(store_lanes(i_f3, 32'(i_WrData)));
            f3_q    <= i_f3;
            fault_q <= 1'b0;
         end else if (state_q == StBusy) begin
            if (dbus.ack) begin
               if (dbus.err) begin
                  fault_q <= 1'b1;
               end else if (!we_q) begin
                  rdata_q <= fmt_data;
               end
            end else if (timeout_hit) begin
               fault_q <= 1'b1;
            end
         end
      end
   end

   load_formatter #(
      .XLEN (XLEN)
   ) u_load_formatter (
      .rdata_i   (dbus.rdata),
      .addr_lo_i (addr_q[1:0]),
      .f3_i      (f3_q),
      .result_o  (fmt_data)
   );

   // Bus outputs come straight from the latched transfer
   assign dbus.req   = (state_q == StBusy);
   assign dbus.we    = we_q;
   assign dbus.addr  = {addr_q[XLEN-1:2], 2'b00};
   assign dbus.wdata = wdata_q;
   assign dbus.be    = be_q;

   // Stall and exception outputs; reset masks the combinational IDLE paths
   always_comb begin
      idle_fault = !i_rst && (state_q == StIdle) && req_valid && chk_fail;
      done_fault = (state_q == StDone) && fault_q;
      o_Stall    = !i_rst && (accept || (state_q == StBusy));
      o_Ex       = idle_fault || done_fault;
      o_ExCause  = '0;
      o_ExAddr   = '0;
      if (idle_fault) begin
         o_ExCause = chk_cause;
         o_ExAddr  = i_Addr;
      end else if (done_fault) begin
         o_ExCause = we_q ? CauseStFault : CauseLdFault;
         o_ExAddr  = addr_q;
      end
      o_RdData = rdata_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven req/ack memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  f3;
   logic [31:0] addr, wr_data;
   logic [31:0] rd_data;
   logic        stall, ex;
   logic [3:0]  ex_cause;
   logic [31:0] ex_addr;

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit_if #(.XLEN(32)) bus ();

   load_store_unit #(
      .TIMEOUT (4),
      .XLEN    (32)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_MemRead  (mem_read),
      .i_MemWrite (mem_write),
      .i_f3       (f3),
      .i_Addr     (addr),
      .i_WrData   (wr_data),
      .o_RdData   (rd_data),
      .o_Stall    (stall),
      .o_Ex       (ex),
      .o_ExCause  (ex_cause),
      .o_ExAddr   (ex_addr),
      .dbus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One access: counts stall/req cycles, records the first bus beat and the
   // exception outputs in the cycle where stall and req are both low.
   task automatic run_access(
      input  logic        ld, st,
      input  logic [2:0]  f3v,
      input  logic [31:0] a, wd, rd,
      input  int          waits,
      input  logic        er, no_ack,
      output int          stalls, reqs,
      output logic [3:0]  be_s,
      output logic        we_s,
      output logic [31:0] addr_s, wdata_s,
      output logic        ex_s,
      output logic [3:0]  cause_s,
      output logic [31:0] exaddr_s,
      output logic        done_s
   );
      int busy_n;
      busy_n = 0; stalls = 0; reqs = 0; be_s = '0; we_s = 1'b0; addr_s = '0;
      wdata_s = '0; ex_s = 1'b0; cause_s = '0; exaddr_s = '0; done_s = 1'b0;
      @(negedge clk);
      mem_read = ld; mem_write = st; f3 = f3v; addr = a; wr_data = wd;
      for (int c = 0; c < 40 && !done_s; c++) begin
         if (c > 0) @(negedge clk);
         bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
         #1;
         if (stall) stalls++;
         if (bus.req) begin
            if (reqs == 0) begin
               be_s = bus.be; we_s = bus.we; addr_s = bus.addr; wdata_s = bus.wdata;
            end
            reqs++;
            if (!no_ack && busy_n == waits) begin
               bus.ack = 1'b1; bus.err = er; bus.rdata = rd;
            end
            busy_n++;
         end
         if (!stall && !bus.req) begin
            ex_s = ex; cause_s = ex_cause; exaddr_s = ex_addr; done_s = 1'b1;
            mem_read = 1'b0; mem_write = 1'b0;
         end
      end
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   initial begin
      int          stalls, reqs;
      logic [3:0]  be_s, cause_s;
      logic        we_s, ex_s, done_s, ex_seen;
      logic [31:0] addr_s, wdata_s, exaddr_s;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; f3 = '0; addr = '0; wr_data = '0;
      bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_req", {31'd0, bus.req}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_ex", {31'd0, ex}, 0);
      chk("rst_rddata", rd_data, 0);
      @(negedge clk); rst = 1'b0;

      // LW 0x100, zero wait states
      run_access(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lw_done", {31'd0, done_s}, 1);
      chk("lw_be", {28'd0, be_s}, 32'hF);
      chk("lw_we", {31'd0, we_s}, 0);
      chk("lw_addr", addr_s, 32'h100);
      chk("lw_stalls", stalls, 2);
      chk("lw_ex", {31'd0, ex_s}, 0);
      chk("lw_data", rd_data, 32'hDEADBEEF);

      // LB / LBU 0x103
      run_access(1, 0, 3'd0, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lb_be", {28'd0, be_s}, 32'h8);
      chk("lb_addr", addr_s, 32'h100);
      chk("lb_data", rd_data, 32'hFFFFFF80);
      run_access(1, 0, 3'd4, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lbu_data", rd_data, 32'h00000080);

      // SH 0x202, 3 wait states; load result must be untouched
      run_access(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 3, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("sh_we", {31'd0, we_s}, 1);
      chk("sh_be", {28'd0, be_s}, 32'hC);
      chk("sh_wdata", wdata_s, 32'hABCDABCD);
      chk("sh_addr", addr_s, 32'h200);
      chk("sh_stalls", stalls, 5);
      chk("sh_ex", {31'd0, ex_s}, 0);
      chk("sh_rddata_kept", rd_data, 32'h00000080);

      // LH / LHU 0x402, upper half
      run_access(1, 0, 3'd1, 32'h402, 0, 32'h80015555, 1, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lh_be", {28'd0, be_s}, 32'hC);
      chk("lh_stalls", stalls, 3);
      chk("lh_data", rd_data, 32'hFFFF8001);
      run_access(1, 0, 3'd5, 32'h402, 0, 32'h80015555, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lhu_data", rd_data, 32'h00008001);

      // SB 0x501 lane replication
      run_access(0, 1, 3'd0, 32'h501, 32'h000000A5, 0, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("sb_be", {28'd0, be_s}, 32'h2);
      chk("sb_wdata", wdata_s, 32'hA5A5A5A5);

      // Misaligned LW 0x101
      run_access(1, 0, 3'd2, 32'h101, 0, 0, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("lw_mis_ex", {31'd0, ex_s}, 1);
      chk("lw_mis_cause", {28'd0, cause_s}, 4);
      chk("lw_mis_addr", exaddr_s, 32'h101);
      chk("lw_mis_reqs", reqs, 0);
      chk("lw_mis_stalls", stalls, 0);

      // Misaligned SW 0x102
      run_access(0, 1, 3'd2, 32'h102, 32'h1, 0, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("sw_mis_cause", {28'd0, cause_s}, 6);
      chk("sw_mis_reqs", reqs, 0);

      // Illegal widths
      run_access(1, 0, 3'd3, 32'h100, 0, 0, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("ld_f3_3_ex", {31'd0, ex_s}, 1);
      chk("ld_f3_3_cause", {28'd0, cause_s}, 2);
      run_access(0, 1, 3'd4, 32'h100, 0, 0, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("st_f3_4_cause", {28'd0, cause_s}, 2);
      chk("st_f3_4_reqs", reqs, 0);

      // SW with bus error
      run_access(0, 1, 3'd2, 32'h300, 32'h5, 0, 0, 1, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("sw_err_ex", {31'd0, ex_s}, 1);
      chk("sw_err_cause", {28'd0, cause_s}, 7);
      chk("sw_err_addr", exaddr_s, 32'h300);
      chk("sw_err_stalls", stalls, 2);

      // LW timeout (TIMEOUT=4)
      run_access(1, 0, 3'd2, 32'h400, 0, 0, 0, 0, 1,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("to_done", {31'd0, done_s}, 1);
      chk("to_reqs", reqs, 4);
      chk("to_stalls", stalls, 5);
      chk("to_cause", {28'd0, cause_s}, 5);
      chk("to_addr", exaddr_s, 32'h400);
      chk("to_rddata_kept", rd_data, 32'h00008001);

      // Both requests high: store wins
      run_access(1, 1, 3'd2, 32'h600, 32'h11223344, 32'hCAFEF00D, 0, 0, 0,
                 stalls, reqs, be_s, we_s, addr_s, wdata_s, ex_s, cause_s, exaddr_s, done_s);
      chk("prio_we", {31'd0, we_s}, 1);
      chk("prio_wdata", wdata_s, 32'h11223344);
      chk("prio_rddata_kept", rd_data, 32'h00008001);

      // Reset during BUSY
      @(negedge clk);
      mem_read = 1'b1; f3 = 3'd2; addr = 32'h700;
      @(negedge clk); #1;
      chk("rst_busy_req_pre", {31'd0, bus.req}, 1);
      rst = 1'b1; #1;
      chk("rst_busy_req", {31'd0, bus.req}, 0);
      chk("rst_busy_stall", {31'd0, stall}, 0);
      chk("rst_busy_ex", {31'd0, ex}, 0);
      @(negedge clk);
      mem_read = 1'b0; rst = 1'b0;
      ex_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         ex_seen = ex_seen | ex | bus.req;
      end
      chk("rst_busy_quiet", {31'd0, ex_seen}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
